fifo_param: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed 16x16 FIFO. It adds configurable width and depth, an occupancy count, and programmable almost-full and almost-empty flags. It also adds sticky overflow/underflow error flags with a clear input, and an optional first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks in a single clock domain and serves as the general-purpose buffer for new datapaths.

---
 rtl/fifo_param.sv | 141 ++++++++++++++
 tb/tb_fifo_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// error flags and an optional first-word-fall-through read port.
//
// Parameters:
//   WIDTH      data word width (>= 1)
//   DEPTH      entries, power of two (>= 2)
//   AF_THRESH  almost-full when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost-empty when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0: registered read data, 1: first-word-fall-through
//
// Ports:
//   clk                rising-edge clock
//   rst_               asynchronous active-high reset
//   fifo_write         write request, data on fifo_data_in
//   fifo_read          read request
//   fifo_clr_err       synchronous clear of both sticky error flags
//   fifo_data_out      read data
//   fifo_full/empty    count == DEPTH / count == 0
//   fifo_almost_full   count >= AF_THRESH
//   fifo_almost_empty  count <= AE_THRESH
//   fifo_count         occupancy 0..DEPTH
//   fifo_overflow      sticky, set by a rejected write
//   fifo_underflow     sticky, set by a rejected read
module fifo_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     fifo_write,
  input  logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_read,
  input  logic                     fifo_clr_err,
  output logic [WIDTH-1:0]         fifo_data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_overflow,
  output logic                     fifo_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             rd_acc;
  logic             wr_acc;
  logic             overflow_q;
  logic             underflow_q;

  // Status flags decode the count register directly.
  assign fifo_count        = count;
  assign fifo_empty        = (count == '0);
  assign fifo_full         = (count == DEPTH_C);
  assign fifo_almost_full  = (count >= AF_C);
  assign fifo_almost_empty = (count <= AE_C);
  assign fifo_overflow     = overflow_q;
  assign fifo_underflow    = underflow_q;

  // A write into a full FIFO is still accepted when a read frees a slot
  // in the same cycle; a read from an empty FIFO never is.
  always_comb begin
    rd_acc = fifo_read && !fifo_empty;
    wr_acc = fifo_write && (!fifo_full || rd_acc);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors: a new error in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (fifo_write && !wr_acc) begin
        overflow_q <= 1'b1;
      end else if (fifo_clr_err) begin
        overflow_q <= 1'b0;
      end
      if (fifo_read && !rd_acc) begin
        underflow_q <= 1'b1;
      end else if (fifo_clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is always presented; meaningless while empty.
      assign fifo_data_out = mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
          fifo_data_out <= '0;
        end else if (rd_acc) begin
          fifo_data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ = 1'b1;
  logic        wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [15:0] din = '0;

  // 16x16, registered read
  logic [15:0] d0;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0]  cnt0;
  // 16x16, first-word-fall-through, same stimulus
  logic [15:0] d1;
  logic        full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]  cnt1;
  // 8x4, registered read, own stimulus
  logic        wr2 = 1'b0, rd2 = 1'b0;
  logic [7:0]  din2 = '0;
  logic [7:0]  d2;
  logic        full2, empty2, af2, ae2, ovf2, unf2;
  logic [2:0]  cnt2;

  fifo_param #(.WIDTH(16), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u0 (
    .clk(clk), .rst_(rst_), .fifo_write(wr), .fifo_data_in(din), .fifo_read(rd),
    .fifo_clr_err(clr), .fifo_data_out(d0), .fifo_full(full0), .fifo_empty(empty0),
    .fifo_almost_full(af0), .fifo_almost_empty(ae0), .fifo_count(cnt0),
    .fifo_overflow(ovf0), .fifo_underflow(unf0));

  fifo_param #(.WIDTH(16), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u1 (
    .clk(clk), .rst_(rst_), .fifo_write(wr), .fifo_data_in(din), .fifo_read(rd),
    .fifo_clr_err(clr), .fifo_data_out(d1), .fifo_full(full1), .fifo_empty(empty1),
    .fifo_almost_full(af1), .fifo_almost_empty(ae1), .fifo_count(cnt1),
    .fifo_overflow(ovf1), .fifo_underflow(unf1));

  fifo_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(0), .FWFT(0)) u2 (
    .clk(clk), .rst_(rst_), .fifo_write(wr2), .fifo_data_in(din2), .fifo_read(rd2),
    .fifo_clr_err(1'b0), .fifo_data_out(d2), .fifo_full(full2), .fifo_empty(empty2),
    .fifo_almost_full(af2), .fifo_almost_empty(ae2), .fifo_count(cnt2),
    .fifo_overflow(ovf2), .fifo_underflow(unf2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read order for u0/u1; stimulus pushes words it expects accepted.
  logic [15:0] exp_q[$];

  // Monitor / scoreboard for u0 and u1.
  int          mcnt = 0;
  logic        movf = 1'b0, munf = 1'b0;
  logic [15:0] mhold = '0;
  initial begin
    logic r_acc, w_acc;
    forever begin
      @(posedge clk or posedge rst_);
      if (rst_) begin
        mcnt = 0; movf = 1'b0; munf = 1'b0; mhold = '0;
        exp_q.delete();
      end else begin
        r_acc = rd && (mcnt > 0);
        w_acc = wr && ((mcnt < 16) || r_acc);
        if (wr && !w_acc) movf = 1'b1; else if (clr) movf = 1'b0;
        if (rd && !r_acc) munf = 1'b1; else if (clr) munf = 1'b0;
        #1;
        if (r_acc) begin
          if (exp_q.size() == 0) chk("sb_queue_empty_on_read", 32'd0, 32'd1);
          else mhold = exp_q.pop_front();
        end
        mcnt += int'(w_acc) - int'(r_acc);
        chk("std_data", 32'(d0), 32'(mhold));
        chk("count0", 32'(cnt0), 32'(mcnt));
        chk("empty0", 32'(empty0), 32'(mcnt == 0));
        chk("full0", 32'(full0), 32'(mcnt == 16));
        chk("afull0", 32'(af0), 32'(mcnt >= 14));
        chk("aempty0", 32'(ae0), 32'(mcnt <= 2));
        chk("ovf0", 32'(ovf0), 32'(movf));
        chk("unf0", 32'(unf0), 32'(munf));
        chk("count1", 32'(cnt1), 32'(mcnt));
        chk("flags1", {28'd0, full1, empty1, af1, ae1},
            {28'd0, mcnt == 16, mcnt == 0, mcnt >= 14, mcnt <= 2});
        chk("err1", {30'd0, ovf1, unf1}, {30'd0, movf, munf});
        if (mcnt > 0) begin
          if (exp_q.size() == 0) chk("sb_queue_empty_fwft", 32'd0, 32'd1);
          else chk("fwft_data", 32'(d1), 32'(exp_q[0]));
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic [15:0] d, input logic r,
                     input logic c, input logic push);
    @(negedge clk);
    wr = w; din = d; rd = r; clr = c;
    if (push) exp_q.push_back(d);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  int          cnt_t [5] = '{1, 2, 3, 4, 4};
  logic        af_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic        ovf_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_flags", {28'd0, full0, empty0, af0, ae0}, 32'b0101);
    chk("rst_err", {30'd0, ovf0, unf0}, 32'd0);
    chk("rst_data", 32'(d0), 32'd0);
    chk("rst_count2", 32'(cnt2), 32'd0);
    chk("rst_ae2", 32'(ae2), 32'd1);
    rst_ = 1'b0;

    // Single write then read
    cyc(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
    after_edge();
    chk("t1_fwft_visible", 32'(d1), 32'h0001);
    chk("t1_count_up", 32'(cnt0), 32'd1);
    chk("t1_std_not_yet", 32'(d0), 32'd0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("t1_std_data", 32'(d0), 32'h0001);
    chk("t1_empty_again", 32'(empty0), 32'd1);

    // Fill with 1..16, then a rejected 17th write
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
      after_edge();
      chk("t2_aempty", 32'(ae0), 32'(i <= 2));
      chk("t2_afull", 32'(af0), 32'(i >= 14));
      chk("t2_full", 32'(full0), 32'(i == 16));
    end
    cyc(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("t2_count_sat", 32'(cnt0), 32'd16);
    chk("t2_overflow", 32'(ovf0), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("t2_ovf_cleared", 32'(ovf0), 32'd0);

    // Full FIFO, read+write together for 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b1);
      after_edge();
      chk("t3_count_full", 32'(cnt0), 32'd16);
      chk("t3_no_ovf", 32'(ovf0), 32'd0);
    end
    chk("t3_last_read", 32'(d0), 32'h0103);
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("t3_drained_last", 32'(d0), 32'h0113);
    chk("t3_drained_empty", 32'(empty0), 32'd1);

    // Empty FIFO, read+write together
    cyc(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b1);
    after_edge();
    chk("t4_count", 32'(cnt0), 32'd1);
    chk("t4_underflow", 32'(unf0), 32'd1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("t4_data", 32'(d0), 32'hABCD);
    chk("t4_unf_held", 32'(unf0), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("t4_unf_cleared", 32'(unf0), 32'd0);

    // Fill 8 entries, asynchronous reset between edges
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("t5_count_before", 32'(cnt0), 32'd8);
    #1 rst_ = 1'b1;
    #1;
    chk("t5_rst_count", 32'(cnt0), 32'd0);
    chk("t5_rst_flags", {28'd0, full0, empty0, af0, ae0}, 32'b0101);
    chk("t5_rst_data", 32'(d0), 32'd0);
    chk("t5_rst_count1", 32'(cnt1), 32'd0);
    #1 rst_ = 1'b0;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("t5_underflow", 32'(unf0), 32'd1);
    chk("t5_count_zero", 32'(cnt0), 32'd0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Small configuration: 8 bits x 4 entries, AF=3, AE=0
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wr2 = 1'b1; din2 = 8'h11 + 8'(k);
      after_edge();
      chk("t6_count", 32'(cnt2), 32'(cnt_t[k]));
      chk("t6_aempty", 32'(ae2), 32'd0);
      chk("t6_afull", 32'(af2), 32'(af_t[k]));
      chk("t6_full", 32'(full2), 32'(cnt_t[k] == 4));
      chk("t6_overflow", 32'(ovf2), 32'(ovf_t[k]));
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      wr2 = 1'b0; rd2 = 1'b1;
      after_edge();
      chk("t6_rd_data", 32'(d2), 32'(8'h11 + 8'(j)));
      chk("t6_rd_count", 32'(cnt2), 32'(3 - j));
      chk("t6_rd_aempty", 32'(ae2), 32'(j == 3));
      chk("t6_rd_afull", 32'(af2), 32'(j == 0));
      chk("t6_rd_empty", 32'(empty2), 32'(j == 3));
    end
    @(negedge clk);
    rd2 = 1'b0;
    chk("t6_no_underflow", 32'(unf2), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
